// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one SRAM-like bus between the instruction-fetch port and the
//   load/store port. One transaction is in flight at a time. The winner's
//   virtual address is translated (kseg0/kseg1 fold onto physical 0) and
//   registered together with the other bus fields at grant time.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   inst_req/addr                  fetch request (held until inst_addr_ok)
//   inst_addr_ok/data_ok/rdata     fetch accept pulse, completion pulse, data
//   data_req/wr/wstrb/addr/wdata   load/store request (held until data_addr_ok)
//   data_addr_ok/data_ok/rdata     load/store accept pulse, completion pulse, data
//   bus_req/wr/wstrb/addr/wdata    registered bus request fields
//   bus_uncached                   registered: access targets kseg1
//   bus_addr_ok/data_ok/rdata      slave handshake and read data
module sram_bus_arbiter #(
    parameter bit DATA_FIRST     = 1'b1,
    parameter int STARVE_MAX     = 4,
    parameter bit KSEG1_UNCACHED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    owner_t      owner;
    logic [3:0]  starve_cnt;

    logic        any_req, both_req, force_low, pick_data, low_wins, grant, done;
    logic [31:0] win_addr, phys_addr;
    logic        win_kseg01, win_kseg1;

    // Arbitration: the high-priority port wins a collision unless the
    // low-priority port has already lost STARVE_MAX times in a row.
    always_comb begin
        any_req   = inst_req | data_req;
        both_req  = inst_req & data_req;
        force_low = (starve_cnt == STARVE_LIM);
        if (both_req)
            pick_data = DATA_FIRST ? ~force_low : force_low;
        else
            pick_data = data_req;
        // low-priority port is inst when DATA_FIRST, data otherwise
        low_wins  = any_req & (pick_data != DATA_FIRST);
        grant     = (state == S_IDLE) & any_req & ~rst;
        done      = (state == S_WAIT) & bus_data_ok & ~rst;
    end

    // Address translation on the winner only; bits [28:0] always pass through.
    always_comb begin
        win_addr   = pick_data ? data_addr : inst_addr;
        win_kseg01 = (win_addr[31:30] == 2'b10);
        win_kseg1  = (win_addr[31:29] == 3'b101);
        phys_addr  = {(win_kseg01 ? 3'b000 : win_addr[31:29]), win_addr[28:0]};
    end

    assign inst_addr_ok = grant & ~pick_data;
    assign data_addr_ok = grant & pick_data;
    assign inst_data_ok = done & (owner == OWN_INST);
    assign data_data_ok = done & (owner == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            owner        <= OWN_NONE;
            starve_cnt   <= 4'd0;
            bus_req      <= 1'b0;
            bus_wr       <= 1'b0;
            bus_wstrb    <= 4'b0000;
            bus_addr     <= 32'd0;
            bus_wdata    <= 32'd0;
            bus_uncached <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state        <= S_REQ;
                        owner        <= pick_data ? OWN_DATA : OWN_INST;
                        bus_req      <= 1'b1;
                        bus_addr     <= phys_addr;
                        bus_uncached <= KSEG1_UNCACHED & win_kseg1;
                        bus_wr       <= pick_data & data_wr;
                        // byte enables only mean something on a store
                        bus_wstrb    <= (pick_data & data_wr) ? data_wstrb : 4'b0000;
                        bus_wdata    <= pick_data ? data_wdata : 32'd0;
                        if (low_wins)
                            starve_cnt <= 4'd0;
                        else if (both_req && starve_cnt != 4'hF)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                S_REQ: begin
                    // bus_data_ok here is a slave protocol error; ignored
                    if (bus_addr_ok) begin
                        state   <= S_WAIT;
                        bus_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus_data_ok) begin
                        state <= S_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule
